// File: rtl/usb_buffer_arbiter.sv
// usb_buffer_arbiter
//   Arbitrates one shared byte-buffer port between USB RX (store), USB TX
//   (get) and an AHB read/write master. USB operations take one cycle. AHB
//   operations take 1, 2 or 4 cycles, one byte lane per cycle. A starvation
//   counter guarantees AHB progress under continuous USB traffic.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | no access on the buffer port this cycle
//   S_USB_OP | single-cycle RX store or TX get
//   S_AHB_OP | AHB read/write, byte_idx steps 0..N-1, ack on last byte
//
// Ports
//   clk, n_rst        clock, synchronous active-high reset
//   rx_store_req      RX byte pulse (held in a one-deep pending register)
//   tx_get_req        TX byte level request
//   ahb_rd_req/wr_req AHB level requests, held until ahb_ack
//   ahb_size          AHB size, sampled at grant (0:1B, 1:2B, 2/3:4B)
//   clear             flush: back to idle, aborts AHB, clears sticky state
//   *_ack             single-cycle completion pulses
//   buf_en/wr/owner   buffer port strobe, write qualifier, owner
//   byte_idx          AHB byte lane
//   ahb_busy          AHB operation in progress
//   rx_overrun        sticky: an RX byte was dropped
module usb_buffer_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx_store_req,
  input  logic       tx_get_req,
  input  logic       ahb_rd_req,
  input  logic       ahb_wr_req,
  input  logic [1:0] ahb_size,
  input  logic       clear,
  output logic       rx_store_ack,
  output logic       tx_get_ack,
  output logic       ahb_ack,
  output logic       buf_en,
  output logic       buf_wr,
  output logic [1:0] buf_owner,
  output logic [1:0] byte_idx,
  output logic       ahb_busy,
  output logic       rx_overrun
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  localparam logic [1:0] OWN_RX = 2'd0;
  localparam logic [1:0] OWN_TX = 2'd1;
  localparam logic [1:0] OWN_RD = 2'd2;
  localparam logic [1:0] OWN_WR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_USB_OP = 2'd1,
    S_AHB_OP = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_rx_pend, w_rx_pend_nxt;
  logic [SW-1:0]   r_starve, w_starve_nxt;
  logic            r_last_rd, w_last_rd_nxt;
  logic [1:0]      r_ahb_last, w_ahb_last_nxt;
  logic            r_buf_en, w_buf_en_nxt;
  logic            r_buf_wr, w_buf_wr_nxt;
  logic [1:0]      r_buf_owner, w_buf_owner_nxt;
  logic [1:0]      r_byte_idx, w_byte_idx_nxt;
  logic            r_rx_ack, w_rx_ack_nxt;
  logic            r_tx_ack, w_tx_ack_nxt;
  logic            r_ahb_ack, w_ahb_ack_nxt;
  logic            r_ahb_busy, w_ahb_busy_nxt;
  logic            r_overrun, w_overrun_nxt;

  logic       w_ahb_fin, w_can_grant;
  logic       w_rd_eff, w_wr_eff, w_ahb_any, w_rx_any, w_force_ahb;
  logic       w_pick_wr;
  logic       w_gnt_rx, w_gnt_tx, w_gnt_ahb;
  logic [1:0] w_size_last, w_idx_inc;

  // Grants are decided in idle and in the last cycle of every operation.
  // The AHB request being acknowledged this cycle is still high at the
  // deciding edge, so it is masked to avoid serving it twice.
  always_comb begin
    w_ahb_fin   = (r_state == S_AHB_OP) && (r_byte_idx == r_ahb_last);
    w_can_grant = (r_state == S_IDLE) || (r_state == S_USB_OP) || w_ahb_fin;
    w_rd_eff    = ahb_rd_req && !(w_ahb_fin && (r_buf_owner == OWN_RD));
    w_wr_eff    = ahb_wr_req && !(w_ahb_fin && (r_buf_owner == OWN_WR));
    w_ahb_any   = w_rd_eff || w_wr_eff;
    w_rx_any    = r_rx_pend || rx_store_req;
    w_force_ahb = w_ahb_any && (r_starve == STARVE_MAX);
    w_pick_wr   = w_wr_eff && (!w_rd_eff || r_last_rd);
    w_idx_inc   = r_byte_idx + 2'd1;
    case (ahb_size)
      2'd0:    w_size_last = 2'd0;
      2'd1:    w_size_last = 2'd1;
      default: w_size_last = 2'd3;
    endcase
  end

  always_comb begin
    w_gnt_rx  = 1'b0;
    w_gnt_tx  = 1'b0;
    w_gnt_ahb = 1'b0;
    if (w_can_grant && !clear) begin
      if (w_force_ahb)     w_gnt_ahb = 1'b1;
      else if (w_rx_any)   w_gnt_rx  = 1'b1;
      else if (tx_get_req) w_gnt_tx  = 1'b1;
      else if (w_ahb_any)  w_gnt_ahb = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt     = S_IDLE;
    w_rx_pend_nxt   = r_rx_pend;
    w_starve_nxt    = r_starve;
    w_last_rd_nxt   = r_last_rd;
    w_ahb_last_nxt  = r_ahb_last;
    w_buf_en_nxt    = 1'b0;
    w_buf_wr_nxt    = 1'b0;
    w_buf_owner_nxt = 2'd0;
    w_byte_idx_nxt  = 2'd0;
    w_rx_ack_nxt    = 1'b0;
    w_tx_ack_nxt    = 1'b0;
    w_ahb_ack_nxt   = 1'b0;
    w_ahb_busy_nxt  = 1'b0;
    w_overrun_nxt   = r_overrun;

    if (clear) begin
      // clear wins over everything, including a same-cycle RX pulse
      w_rx_pend_nxt = 1'b0;
      w_starve_nxt  = '0;
      w_overrun_nxt = 1'b0;
    end else begin
      // A pulse coinciding with the grant of the pending byte re-fills it.
      if (w_gnt_rx) begin
        w_rx_pend_nxt = r_rx_pend && rx_store_req;
      end else if (rx_store_req) begin
        if (r_rx_pend) w_overrun_nxt = 1'b1;
        w_rx_pend_nxt = 1'b1;
      end

      if (w_gnt_ahb || !w_ahb_any)     w_starve_nxt = '0;
      else if (w_gnt_rx || w_gnt_tx)   w_starve_nxt = r_starve + SW'(1);

      if (r_state == S_AHB_OP && !w_ahb_fin) begin
        w_state_nxt     = S_AHB_OP;
        w_buf_en_nxt    = 1'b1;
        w_buf_wr_nxt    = r_buf_wr;
        w_buf_owner_nxt = r_buf_owner;
        w_byte_idx_nxt  = w_idx_inc;
        w_ahb_busy_nxt  = 1'b1;
        w_ahb_ack_nxt   = (w_idx_inc == r_ahb_last);
      end else if (w_gnt_ahb) begin
        w_state_nxt     = S_AHB_OP;
        w_buf_en_nxt    = 1'b1;
        w_buf_wr_nxt    = w_pick_wr;
        w_buf_owner_nxt = w_pick_wr ? OWN_WR : OWN_RD;
        w_ahb_busy_nxt  = 1'b1;
        w_ahb_last_nxt  = w_size_last;
        w_ahb_ack_nxt   = (w_size_last == 2'd0);
        w_last_rd_nxt   = !w_pick_wr;
      end else if (w_gnt_rx) begin
        w_state_nxt     = S_USB_OP;
        w_buf_en_nxt    = 1'b1;
        w_buf_wr_nxt    = 1'b1;
        w_buf_owner_nxt = OWN_RX;
        w_rx_ack_nxt    = 1'b1;
      end else if (w_gnt_tx) begin
        w_state_nxt     = S_USB_OP;
        w_buf_en_nxt    = 1'b1;
        w_buf_owner_nxt = OWN_TX;
        w_tx_ack_nxt    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state     <= S_IDLE;
      r_rx_pend   <= 1'b0;
      r_starve    <= '0;
      r_last_rd   <= 1'b1;
      r_ahb_last  <= 2'd0;
      r_buf_en    <= 1'b0;
      r_buf_wr    <= 1'b0;
      r_buf_owner <= 2'd0;
      r_byte_idx  <= 2'd0;
      r_rx_ack    <= 1'b0;
      r_tx_ack    <= 1'b0;
      r_ahb_ack   <= 1'b0;
      r_ahb_busy  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rx_pend   <= w_rx_pend_nxt;
      r_starve    <= w_starve_nxt;
      r_last_rd   <= w_last_rd_nxt;
      r_ahb_last  <= w_ahb_last_nxt;
      r_buf_en    <= w_buf_en_nxt;
      r_buf_wr    <= w_buf_wr_nxt;
      r_buf_owner <= w_buf_owner_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_rx_ack    <= w_rx_ack_nxt;
      r_tx_ack    <= w_tx_ack_nxt;
      r_ahb_ack   <= w_ahb_ack_nxt;
      r_ahb_busy  <= w_ahb_busy_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign rx_store_ack = r_rx_ack;
  assign tx_get_ack   = r_tx_ack;
  assign ahb_ack      = r_ahb_ack;
  assign buf_en       = r_buf_en;
  assign buf_wr       = r_buf_wr;
  assign buf_owner    = r_buf_owner;
  assign byte_idx     = r_byte_idx;
  assign ahb_busy     = r_ahb_busy;
  assign rx_overrun   = r_overrun;

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Directed bench for usb_buffer_arbiter. Each step pushes the output vector
// expected after the next clock edge into a queue; the vector is popped and
// compared just after that edge.
module tb_usb_buffer_arbiter;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rx_store_req, tx_get_req, ahb_rd_req, ahb_wr_req, clear;
  logic [1:0] ahb_size;
  logic       rx_store_ack, tx_get_ack, ahb_ack, buf_en, buf_wr;
  logic [1:0] buf_owner, byte_idx;
  logic       ahb_busy, rx_overrun;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] obs;

  usb_buffer_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .n_rst(n_rst),
    .rx_store_req(rx_store_req), .tx_get_req(tx_get_req),
    .ahb_rd_req(ahb_rd_req), .ahb_wr_req(ahb_wr_req),
    .ahb_size(ahb_size), .clear(clear),
    .rx_store_ack(rx_store_ack), .tx_get_ack(tx_get_ack), .ahb_ack(ahb_ack),
    .buf_en(buf_en), .buf_wr(buf_wr), .buf_owner(buf_owner),
    .byte_idx(byte_idx), .ahb_busy(ahb_busy), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  assign obs = {buf_en, buf_wr, buf_owner, byte_idx, rx_store_ack,
                tx_get_ack, ahb_ack, ahb_busy, rx_overrun};

  // {en, wr, owner, idx, rx_ack, tx_ack, ahb_ack, busy, overrun}
  function automatic logic [10:0] ev(input logic en, input logic wr,
                                     input logic [1:0] own, input logic [1:0] idx,
                                     input logic rxa, input logic txa,
                                     input logic aa, input logic bsy,
                                     input logic ovr);
    return {en, wr, own, idx, rxa, txa, aa, bsy, ovr};
  endfunction

  task automatic cyc(input string tag, input logic [10:0] e);
    logic [10:0] ex;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    ex = exp_q.pop_front();
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
    end
  endtask

  initial begin
    n_rst = 1'b1; rx_store_req = 1'b0; tx_get_req = 1'b0;
    ahb_rd_req = 1'b0; ahb_wr_req = 1'b0; ahb_size = 2'd0; clear = 1'b0;

    // reset holds outputs at zero even with requests present
    cyc("reset0", ev(0,0,0,0,0,0,0,0,0));
    rx_store_req = 1'b1;
    cyc("reset_rx", ev(0,0,0,0,0,0,0,0,0));

    // first grant on the edge after release; single RX pulse
    n_rst = 1'b0;
    cyc("rx_grant", ev(1,1,0,0,1,0,0,0,0));
    rx_store_req = 1'b0;
    cyc("rx_once", ev(0,0,0,0,0,0,0,0,0));

    // RX beats TX; TX served right after
    rx_store_req = 1'b1; tx_get_req = 1'b1;
    cyc("prio_rx", ev(1,1,0,0,1,0,0,0,0));
    rx_store_req = 1'b0;
    cyc("prio_tx", ev(1,0,1,0,0,1,0,0,0));
    tx_get_req = 1'b0;
    cyc("prio_idle", ev(0,0,0,0,0,0,0,0,0));

    // 4-byte AHB write, RX pulse in 2nd cycle served right after the op
    ahb_wr_req = 1'b1; ahb_size = 2'd2;
    cyc("wr4_b0", ev(1,1,3,0,0,0,0,1,0));
    cyc("wr4_b1", ev(1,1,3,1,0,0,0,1,0));
    rx_store_req = 1'b1;
    cyc("wr4_b2", ev(1,1,3,2,0,0,0,1,0));
    rx_store_req = 1'b0;
    cyc("wr4_b3", ev(1,1,3,3,0,0,1,1,0));
    ahb_wr_req = 1'b0;
    cyc("wr4_rx", ev(1,1,0,0,1,0,0,0,0));
    cyc("wr4_idle", ev(0,0,0,0,0,0,0,0,0));

    // 4-byte AHB read (size 3), two RX pulses two cycles apart -> overrun
    ahb_rd_req = 1'b1; ahb_size = 2'd3;
    cyc("rd4_b0", ev(1,0,2,0,0,0,0,1,0));
    rx_store_req = 1'b1;
    cyc("rd4_b1", ev(1,0,2,1,0,0,0,1,0));
    rx_store_req = 1'b0;
    cyc("rd4_b2", ev(1,0,2,2,0,0,0,1,0));
    rx_store_req = 1'b1;
    cyc("rd4_b3_ovr", ev(1,0,2,3,0,0,1,1,1));
    rx_store_req = 1'b0; ahb_rd_req = 1'b0;
    cyc("ovr_rx_once", ev(1,1,0,0,1,0,0,0,1));
    cyc("ovr_idle", ev(0,0,0,0,0,0,0,0,1));

    // clear mid 4-byte write: idle next cycle, no ack, overrun cleared
    ahb_wr_req = 1'b1; ahb_size = 2'd2;
    cyc("clr_b0", ev(1,1,3,0,0,0,0,1,1));
    cyc("clr_b1", ev(1,1,3,1,0,0,0,1,1));
    clear = 1'b1; ahb_wr_req = 1'b0; rx_store_req = 1'b1;
    cyc("clr_abort", ev(0,0,0,0,0,0,0,0,0));
    clear = 1'b0; rx_store_req = 1'b0;
    cyc("clr_drop_rx", ev(0,0,0,0,0,0,0,0,0));

    // starvation: 8 TX grants, then a 1-byte AHB read, then TX resumes
    tx_get_req = 1'b1; ahb_rd_req = 1'b1; ahb_size = 2'd0;
    for (int i = 0; i < 8; i++) cyc($sformatf("starve_tx%0d", i), ev(1,0,1,0,0,1,0,0,0));
    cyc("starve_ahb", ev(1,0,2,0,0,0,1,1,0));
    ahb_rd_req = 1'b0;
    cyc("starve_tx_resume", ev(1,0,1,0,0,1,0,0,0));
    tx_get_req = 1'b0;
    cyc("starve_idle", ev(0,0,0,0,0,0,0,0,0));

    // reset aborts an AHB op with no ack
    ahb_wr_req = 1'b1; ahb_size = 2'd2;
    cyc("rst_b0", ev(1,1,3,0,0,0,0,1,0));
    cyc("rst_b1", ev(1,1,3,1,0,0,0,1,0));
    n_rst = 1'b1; ahb_wr_req = 1'b0;
    cyc("rst_abort", ev(0,0,0,0,0,0,0,0,0));

    // both AHB requests held, 1-byte ops: write first after reset, alternate
    n_rst = 1'b0; ahb_rd_req = 1'b1; ahb_wr_req = 1'b1; ahb_size = 2'd0;
    cyc("alt_wr0", ev(1,1,3,0,0,0,1,1,0));
    cyc("alt_rd0", ev(1,0,2,0,0,0,1,1,0));
    cyc("alt_wr1", ev(1,1,3,0,0,0,1,1,0));
    cyc("alt_rd1", ev(1,0,2,0,0,0,1,1,0));
    ahb_rd_req = 1'b0; ahb_wr_req = 1'b0;
    cyc("alt_idle", ev(0,0,0,0,0,0,0,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
